// File: rtl/satadev_rxlink_if.sv
// Signal bundle for the device-side SATA receive link: host dword stream in,
// handshake primitives out, and the payload beat stream to the FIS buffer.
interface satadev_rxlink_if;
    logic        rx_valid;
    logic        rx_primitive;
    logic [31:0] rx_data;
    logic        tx_primitive;
    logic [31:0] tx_data;
    logic        beat_valid;
    logic [31:0] beat_data;
    logic        beat_last;
    logic        beat_abort;
    logic        full;
    logic        busy;
    logic        crc_err;

    modport master (
        output rx_valid, rx_primitive, rx_data, full,
        input  tx_primitive, tx_data, beat_valid, beat_data, beat_last, beat_abort, busy, crc_err
    );

    modport slave (
        input  rx_valid, rx_primitive, rx_data, full,
        output tx_primitive, tx_data, beat_valid, beat_data, beat_last, beat_abort, busy, crc_err
    );
endinterface

// File: rtl/satadev_rxlink.sv
// Device-side SATA link receive responder: answers the host handshake, strips
// SOF/EOF framing, checks the frame CRC and streams the payload out.
module satadev_rxlink #(
    parameter logic [31:0] P_SYNC     = 32'hB5B5957C,
    parameter logic [31:0] P_X_RDY    = 32'h5757B57C,
    parameter logic [31:0] P_R_RDY    = 32'h4A4A957C,
    parameter logic [31:0] P_R_IP     = 32'h5555B57C,
    parameter logic [31:0] P_R_OK     = 32'h3535B57C,
    parameter logic [31:0] P_R_ERR    = 32'h5656B57C,
    parameter logic [31:0] P_SOF      = 32'h3737B57C,
    parameter logic [31:0] P_EOF      = 32'hD5D5B57C,
    parameter logic [31:0] P_WTRM     = 32'h5858B57C,
    parameter logic [31:0] P_HOLD     = 32'hD5D5AA7C,
    parameter logic [31:0] P_HOLDA    = 32'h9595AA7C,
    parameter bit          OPT_CRC    = 1'b1,
    parameter int          MAX_DWORDS = 2049
) (
    input logic             clk,
    input logic             rst_n,
    satadev_rxlink_if.slave link
);
    localparam logic [31:0] CRC_SEED = 32'h52325032;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam int          BW       = $clog2(MAX_DWORDS + 1);

    typedef enum logic [2:0] {IDLE, RDY, RECV, CHECK, GOOD_BAD} state_t;

    state_t        state, state_nx;
    logic [31:0]   crc, crc_nx, crc_final;
    logic [31:0]   d0, d0_nx, d1, d1_nx;
    logic [1:0]    cnt, cnt_nx;
    logic [BW-1:0] body, body_nx;
    logic          emitted, emitted_nx;
    logic          last_hold, last_hold_nx;
    logic          good, good_nx;
    logic [31:0]   tx_nx, beat_data_nx;
    logic          beat_valid_nx, beat_last_nx, beat_abort_nx, crc_err_nx;
    logic          is_data, got_xrdy, got_sof, got_eof, got_sync, got_wtrm, got_hold;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 31; i >= 0; i--)
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
        return r;
    endfunction

    assign is_data  = link.rx_valid && !link.rx_primitive;
    assign got_xrdy = link.rx_valid && link.rx_primitive && (link.rx_data == P_X_RDY);
    assign got_sof  = link.rx_valid && link.rx_primitive && (link.rx_data == P_SOF);
    assign got_eof  = link.rx_valid && link.rx_primitive && (link.rx_data == P_EOF);
    assign got_sync = link.rx_valid && link.rx_primitive && (link.rx_data == P_SYNC);
    assign got_wtrm = link.rx_valid && link.rx_primitive && (link.rx_data == P_WTRM);
    assign got_hold = link.rx_valid && link.rx_primitive && (link.rx_data == P_HOLD);

    assign link.tx_primitive = 1'b1;

    always_comb begin
        state_nx      = state;
        crc_nx        = crc;
        d0_nx         = d0;
        d1_nx         = d1;
        cnt_nx        = cnt;
        body_nx       = body;
        emitted_nx    = emitted;
        last_hold_nx  = last_hold;
        good_nx       = good;
        beat_valid_nx = 1'b0;
        beat_last_nx  = 1'b0;
        beat_abort_nx = 1'b0;
        beat_data_nx  = link.beat_data;
        crc_err_nx    = 1'b0;
        tx_nx         = P_SYNC;
        // The newest held dword is the CRC candidate, so d1 is folded in only when it is known to be payload.
        crc_final     = crc_next(crc, d1);

        case (state)
            IDLE: if (got_xrdy) state_nx = RDY;
            RDY: begin
                if (got_sof) begin
                    state_nx     = RECV;
                    crc_nx       = CRC_SEED;
                    cnt_nx       = 2'd0;
                    body_nx      = '0;
                    emitted_nx   = 1'b0;
                    last_hold_nx = 1'b0;
                end else if (got_sync) begin
                    state_nx = IDLE;
                end
            end
            RECV: begin
                if (link.rx_valid) last_hold_nx = got_hold;
                if (is_data) begin
                    if (body == BW'(MAX_DWORDS)) begin
                        state_nx      = GOOD_BAD;
                        good_nx       = 1'b0;
                        beat_valid_nx = 1'b1;
                        beat_last_nx  = 1'b1;
                        beat_abort_nx = 1'b1;
                        beat_data_nx  = 32'h0;
                    end else begin
                        body_nx = body + BW'(1);
                        d1_nx   = d0;
                        d0_nx   = link.rx_data;
                        if (cnt == 2'd2) begin
                            beat_valid_nx = 1'b1;
                            beat_data_nx  = d1;
                            crc_nx        = crc_final;
                            emitted_nx    = 1'b1;
                        end else begin
                            cnt_nx = cnt + 2'd1;
                        end
                    end
                end else if (got_eof) begin
                    state_nx      = CHECK;
                    beat_valid_nx = 1'b1;
                    beat_last_nx  = 1'b1;
                    if (cnt == 2'd2) begin
                        beat_data_nx = d1;
                        if (OPT_CRC && (crc_final != d0)) begin
                            beat_abort_nx = 1'b1;
                            crc_err_nx    = 1'b1;
                            good_nx       = 1'b0;
                        end else begin
                            good_nx = 1'b1;
                        end
                    end else begin
                        beat_abort_nx = 1'b1;
                        beat_data_nx  = 32'h0;
                        good_nx       = 1'b0;
                    end
                end else if (got_sync || got_wtrm) begin
                    state_nx = got_sync ? IDLE : GOOD_BAD;
                    good_nx  = 1'b0;
                    if (emitted) begin
                        beat_valid_nx = 1'b1;
                        beat_last_nx  = 1'b1;
                        beat_abort_nx = 1'b1;
                        beat_data_nx  = 32'h0;
                    end
                end
            end
            CHECK:    state_nx = GOOD_BAD;
            GOOD_BAD: if (got_sync) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase

        case (state_nx)
            IDLE:     tx_nx = P_SYNC;
            RDY:      tx_nx = P_R_RDY;
            RECV:     tx_nx = link.full ? P_HOLD : (last_hold_nx ? P_HOLDA : P_R_IP);
            CHECK:    tx_nx = P_R_IP;
            GOOD_BAD: tx_nx = good_nx ? P_R_OK : P_R_ERR;
            default:  tx_nx = P_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            crc             <= CRC_SEED;
            d0              <= 32'h0;
            d1              <= 32'h0;
            cnt             <= 2'd0;
            body            <= '0;
            emitted         <= 1'b0;
            last_hold       <= 1'b0;
            good            <= 1'b0;
            link.tx_data    <= P_SYNC;
            link.beat_valid <= 1'b0;
            link.beat_data  <= 32'h0;
            link.beat_last  <= 1'b0;
            link.beat_abort <= 1'b0;
            link.busy       <= 1'b0;
            link.crc_err    <= 1'b0;
        end else begin
            state           <= state_nx;
            crc             <= crc_nx;
            d0              <= d0_nx;
            d1              <= d1_nx;
            cnt             <= cnt_nx;
            body            <= body_nx;
            emitted         <= emitted_nx;
            last_hold       <= last_hold_nx;
            good            <= good_nx;
            link.tx_data    <= tx_nx;
            link.beat_valid <= beat_valid_nx;
            link.beat_data  <= beat_data_nx;
            link.beat_last  <= beat_last_nx;
            link.beat_abort <= beat_abort_nx;
            link.busy       <= (state_nx != IDLE);
            link.crc_err    <= crc_err_nx;
        end
    end
endmodule

// File: tb/tb_satadev_rxlink.sv
// Self-checking bench for satadev_rxlink: directed and randomized frames checked
// against a frame-level model with a byte-table CRC reference.
module tb_satadev_rxlink;
    localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] P_X_RDY = 32'h5757B57C;
    localparam logic [31:0] P_R_RDY = 32'h4A4A957C;
    localparam logic [31:0] P_R_IP  = 32'h5555B57C;
    localparam logic [31:0] P_R_OK  = 32'h3535B57C;
    localparam logic [31:0] P_R_ERR = 32'h5656B57C;
    localparam logic [31:0] P_SOF   = 32'h3737B57C;
    localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] P_WTRM  = 32'h5858B57C;
    localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] P_HOLDA = 32'h9595AA7C;
    localparam logic [31:0] POLY    = 32'h04C11DB7;
    localparam logic [31:0] SEED    = 32'h52325032;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        abort;
    } beat_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          crc_err_pulses = 0;
    beat_t       got_q[$];
    logic [31:0] crc_tab[256];

    satadev_rxlink_if link ();

    satadev_rxlink dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (link)
    );

    always #5 clk = ~clk;

    // Collect every emitted beat shortly after the edge that produced it.
    always begin
        beat_t b;
        @(posedge clk);
        #2;
        if (link.beat_valid === 1'b1) begin
            b = {link.beat_data, link.beat_last, link.beat_abort};
            got_q.push_back(b);
        end
        if (link.crc_err === 1'b1) crc_err_pulses++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one dword at a negedge; returns at the next negedge with outputs settled.
    task automatic apply_stimulus(input logic v, input logic p, input logic [31:0] d);
        link.rx_valid     = v;
        link.rx_primitive = p;
        link.rx_data      = d;
        @(negedge clk);
    endtask

    function automatic logic [31:0] ref_crc(input logic [31:0] words[$]);
        logic [31:0] c;
        logic [7:0]  idx;
        c = SEED;
        foreach (words[i])
            for (int k = 3; k >= 0; k--) begin
                idx = c[31:24] ^ words[i][8*k +: 8];
                c   = (c << 8) ^ crc_tab[idx];
            end
        return c;
    endfunction

    task automatic run_frame(input string name, input logic [31:0] payload[$], input bit corrupt,
                             input int full_lo, input int full_len, input int hold_at);
        logic [31:0] body[$];
        beat_t       exp_b;
        int          cyc;
        int          n0;
        int          errs0;
        bit          f;
        body = payload;
        body.push_back(ref_crc(payload) ^ (corrupt ? 32'h1 : 32'h0));
        got_q.delete();
        errs0 = crc_err_pulses;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, P_X_RDY);
            check_output({name, " xrdy"}, 64'(link.tx_data), 64'(P_R_RDY));
        end
        check_output({name, " busy"}, 64'(link.busy), 64'(1));
        apply_stimulus(1'b1, 1'b1, P_SOF);
        check_output({name, " sof"}, 64'(link.tx_data), 64'(P_R_IP));
        cyc = 0;
        for (int i = 0; i < body.size(); i++) begin
            if (i == hold_at) begin
                n0 = got_q.size();
                for (int h = 0; h < 5; h++) begin
                    f = (cyc >= full_lo) && (cyc < full_lo + full_len);
                    link.full = f;
                    apply_stimulus(1'b1, 1'b1, P_HOLD);
                    check_output({name, " hold"}, 64'(link.tx_data), 64'(f ? P_HOLD : P_HOLDA));
                    cyc++;
                end
                check_output({name, " no beats in hold"}, 64'(got_q.size()), 64'(n0));
            end
            f = (cyc >= full_lo) && (cyc < full_lo + full_len);
            link.full = f;
            apply_stimulus(1'b1, 1'b0, body[i]);
            check_output({name, " body"}, 64'(link.tx_data), 64'(f ? P_HOLD : P_R_IP));
            cyc++;
        end
        link.full = 1'b0;
        apply_stimulus(1'b1, 1'b1, P_EOF);
        check_output({name, " eof"}, 64'(link.tx_data), 64'(P_R_IP));
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b1, P_WTRM);
            check_output({name, " result"}, 64'(link.tx_data), 64'(corrupt ? P_R_ERR : P_R_OK));
        end
        apply_stimulus(1'b1, 1'b1, P_SYNC);
        check_output({name, " sync"}, 64'(link.tx_data), 64'(P_SYNC));
        check_output({name, " idle busy"}, 64'(link.busy), 64'(0));
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output({name, " beat count"}, 64'(got_q.size()), 64'(payload.size()));
        foreach (payload[i]) begin
            exp_b = {payload[i], i == payload.size() - 1, corrupt && (i == payload.size() - 1)};
            if (i < got_q.size())
                check_output({name, " beat"}, 64'(got_q[i]), 64'(exp_b));
        end
        check_output({name, " crc_err pulses"}, 64'(crc_err_pulses - errs0), 64'(corrupt));
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] pl[$];
        logic [31:0] ov[$];
        beat_t       exp_b;
        int          n;
        bit          bad;

        for (int idx = 0; idx < 256; idx++) begin
            v = 32'(idx) << 24;
            for (int b = 0; b < 8; b++) v = v[31] ? ((v << 1) ^ POLY) : (v << 1);
            crc_tab[idx] = v;
        end

        link.rx_valid = 1'b0;
        link.rx_primitive = 1'b0;
        link.rx_data = 32'h0;
        link.full = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset tx_data", 64'(link.tx_data), 64'(P_SYNC));
        check_output("reset tx_primitive", 64'(link.tx_primitive), 64'(1));
        check_output("reset beat_valid", 64'(link.beat_valid), 64'(0));
        check_output("reset beat_last", 64'(link.beat_last), 64'(0));
        check_output("reset beat_abort", 64'(link.beat_abort), 64'(0));
        check_output("reset beat_data", 64'(link.beat_data), 64'(0));
        check_output("reset busy", 64'(link.busy), 64'(0));
        check_output("reset crc_err", 64'(link.crc_err), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        pl.delete();
        for (int i = 1; i <= 5; i++) pl.push_back(32'(i) * 32'h11111111);
        run_frame("good5", pl, 1'b0, 0, 0, -1);
        run_frame("badcrc", pl, 1'b1, 0, 0, -1);

        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back($urandom);
        run_frame("full6", pl, 1'b0, 8, 6, -1);

        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back($urandom);
        run_frame("hold5", pl, 1'b0, 0, 0, 4);

        repeat (4) begin
            n = $urandom_range(1, 24);
            bad = 1'($urandom_range(0, 1));
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back($urandom);
            run_frame("random", pl, bad, $urandom_range(0, n), $urandom_range(0, 8), $urandom_range(1, n));
        end

        // Host gives up with SYNC after three data dwords.
        got_q.delete();
        apply_stimulus(1'b1, 1'b1, P_X_RDY);
        apply_stimulus(1'b1, 1'b1, P_SOF);
        for (int i = 1; i <= 3; i++) apply_stimulus(1'b1, 1'b0, 32'(i) * 32'h11111111);
        apply_stimulus(1'b1, 1'b1, P_SYNC);
        check_output("sync abort tx", 64'(link.tx_data), 64'(P_SYNC));
        check_output("sync abort busy", 64'(link.busy), 64'(0));
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("sync abort count", 64'(got_q.size()), 64'(2));
        if (got_q.size() == 2) begin
            exp_b = {32'h11111111, 1'b0, 1'b0};
            check_output("sync abort beat0", 64'(got_q[0]), 64'(exp_b));
            exp_b = {32'h0, 1'b1, 1'b1};
            check_output("sync abort beat1", 64'(got_q[1]), 64'(exp_b));
        end

        // Empty frame: EOF straight after SOF.
        got_q.delete();
        apply_stimulus(1'b1, 1'b1, P_X_RDY);
        apply_stimulus(1'b1, 1'b1, P_SOF);
        apply_stimulus(1'b1, 1'b1, P_EOF);
        apply_stimulus(1'b1, 1'b1, P_WTRM);
        check_output("empty result", 64'(link.tx_data), 64'(P_R_ERR));
        apply_stimulus(1'b1, 1'b1, P_SYNC);
        check_output("empty count", 64'(got_q.size()), 64'(1));
        if (got_q.size() == 1) begin
            exp_b = {32'h0, 1'b1, 1'b1};
            check_output("empty beat", 64'(got_q[0]), 64'(exp_b));
        end

        // WTRM before any beat went out: bad result, no abort beat.
        got_q.delete();
        apply_stimulus(1'b1, 1'b1, P_X_RDY);
        apply_stimulus(1'b1, 1'b1, P_SOF);
        apply_stimulus(1'b1, 1'b0, 32'hCAFEF00D);
        apply_stimulus(1'b1, 1'b1, P_WTRM);
        check_output("early wtrm result", 64'(link.tx_data), 64'(P_R_ERR));
        apply_stimulus(1'b1, 1'b1, P_SYNC);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("early wtrm count", 64'(got_q.size()), 64'(0));

        // One dword beyond the largest legal body.
        got_q.delete();
        ov.delete();
        apply_stimulus(1'b1, 1'b1, P_X_RDY);
        apply_stimulus(1'b1, 1'b1, P_SOF);
        for (int i = 0; i < 2050; i++) begin
            ov.push_back($urandom);
            apply_stimulus(1'b1, 1'b0, ov[i]);
        end
        check_output("overflow result", 64'(link.tx_data), 64'(P_R_ERR));
        apply_stimulus(1'b1, 1'b0, $urandom);
        apply_stimulus(1'b1, 1'b1, P_SYNC);
        check_output("overflow sync", 64'(link.tx_data), 64'(P_SYNC));
        check_output("overflow count", 64'(got_q.size()), 64'(2048));
        if (got_q.size() == 2048) begin
            exp_b = {ov[0], 1'b0, 1'b0};
            check_output("overflow first", 64'(got_q[0]), 64'(exp_b));
            exp_b = {ov[2046], 1'b0, 1'b0};
            check_output("overflow last good", 64'(got_q[2046]), 64'(exp_b));
            exp_b = {32'h0, 1'b1, 1'b1};
            check_output("overflow abort", 64'(got_q[2047]), 64'(exp_b));
        end

        // Asynchronous reset while a beat is on the output.
        apply_stimulus(1'b1, 1'b1, P_X_RDY);
        apply_stimulus(1'b1, 1'b1, P_SOF);
        for (int i = 1; i <= 3; i++) apply_stimulus(1'b1, 1'b0, 32'(i) * 32'h01010101);
        check_output("pre-reset beat", 64'(link.beat_valid), 64'(1));
        link.rx_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_output("async reset tx", 64'(link.tx_data), 64'(P_SYNC));
        check_output("async reset beat_valid", 64'(link.beat_valid), 64'(0));
        check_output("async reset busy", 64'(link.busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pl.delete();
        for (int i = 1; i <= 5; i++) pl.push_back(32'(i) * 32'h11111111);
        run_frame("after reset", pl, 1'b0, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
